sram_line_master: RTL and testbench
===================================

// Module: sram_line_master
// PURPOSE
// - Initiator-side controller for the single-port sram block: turns one client line request into LINE_WORDS word accesses.
// - Write line: one word per cycle. Read line: pipelined, one word issued per cycle, each word returned next cycle.
// - Sits between cache/client logic and sram. Owns the "never re and we together" rule.
// - Owns the one-cycle read-latency bookkeeping.
// PARAMETERS
// - DATA_WIDTH  32  sram word width
// - ADDR_WIDTH   4  sram word address width
// - LINE_WORDS   4  words per line; power of 2, >=2
// - localparam OFF_W = $clog2(LINE_WORDS); LADDR_W = ADDR_WIDTH-OFF_W
// PORTS
// - clk           in   1                      clock
// - rst_n         in   1                      reset, synchronous, active-low
// - req_valid     in   1                      client request valid
// - req_ready     out  1                      master can accept request
// - req_we        in   1                      1=line write, 0=line read
// - req_laddr     in   LADDR_W                line address
// - req_wdata     in   LINE_WORDS*DATA_WIDTH  write line; word i at [i*DW +: DW]
// - rsp_valid     out  1                      transaction complete
// - rsp_ready     in   1                      client accepts response
// - rsp_rdata     out  LINE_WORDS*DATA_WIDTH  read line, same packing as req_wdata
// - mem_addr      out  ADDR_WIDTH             sram addr = {laddr, word_cnt}
// - mem_re        out  1                      sram read enable
// - mem_we        out  1                      sram write enable
// - mem_data_in   out  DATA_WIDTH             sram write data
// - mem_data_out  in   DATA_WIDTH             sram read data, valid the cycle after mem_re
// BEHAVIOUR
// - Reset state: IDLE. Values held during reset:
//   - req_ready=0, rsp_valid=0, rsp_rdata=0
//   - mem_re=0, mem_we=0, mem_addr=0, mem_data_in=0
//   - word_cnt=0, capture pipe cleared
// - States: IDLE, WRITE, READ, RESP.
// - req_ready = (state==IDLE) && rst_n.
// - Accept: req_valid && req_ready at an edge latches req_we, req_laddr and req_wdata.
//   - State then goes to WRITE or READ, with word_cnt=0.
// - WRITE (LINE_WORDS cycles), each cycle:
//   - mem_we=1, mem_re=0, mem_addr={laddr,word_cnt}, mem_data_in=word[word_cnt]
//   - word_cnt increments each cycle.
//   - After the last word, go to RESP. rsp_valid rises LINE_WORDS edges after the accept edge.
//   - rsp_rdata is unchanged by writes.
// - READ (LINE_WORDS+1 cycles):
//   - Issue cycles 0..LINE_WORDS-1: mem_re=1, mem_we=0, mem_addr={laddr,word_cnt}.
//   - Word issued in cycle k is sampled from mem_data_out in cycle k+1 into rsp_rdata slot k.
//   - Final cycle: mem_re=0, last capture only.
//   - Then go to RESP. rsp_valid rises LINE_WORDS+1 edges after the accept edge.
// - RESP:
//   - rsp_valid=1; rsp_rdata stable; mem_re=mem_we=0.
//   - Leave to IDLE on rsp_valid && rsp_ready.
//   - The next request is accepted no earlier than the cycle after that handshake.
// - Invariant: mem_re && mem_we is never 1 in any cycle.
//   - mem_re and mem_we are 0 in IDLE and RESP.
// - mem_addr and mem_data_in outside active cycles: hold the last value. No sram access occurs.
// - word_cnt is OFF_W bits and wraps naturally. Terminal test is word_cnt==LINE_WORDS-1.
// - req_valid while not ready: ignored, not queued. Client must hold it until accepted.
// - Reset mid-operation: IDLE at the next edge.
//   - No response is produced.
//   - Words already written stay written.
//   - Partial read data in rsp_rdata is discarded (cleared to 0).
// - rsp_ready while rsp_valid=0: no effect.
// CONFIGURATION
// - Macro SRAM_LINE_MASTER_STATS_EN.
// - Defined: adds two outputs.
//   - stat_reads out 16: count of read transactions completed at the rsp handshake.
//   - stat_writes out 16: same, for write transactions.
//   - Both saturate at 16'hFFFF and reset to 0.
// - Undefined: ports and counters absent. All other behaviour identical.
// TESTING (DW=32, AW=4, LINE_WORDS=4)
// - Write laddr=1, wdata={44,33,22,11}h:
//   - mem_we=1 at addr 4,5,6,7 in 4 consecutive cycles, data 11,22,33,44.
//   - rsp_valid 4 edges after accept.
// - Read laddr=1 after that write:
//   - mem_re at addr 4..7; rsp_valid 5 edges after accept.
//   - rsp_rdata=128'h00000044_00000033_00000022_00000011.
// - Backpressure: rsp_ready=0 for 3 cycles in RESP.
//   - rsp_valid/rsp_rdata held, req_ready=0.
//   - IDLE the edge after rsp_ready=1.
// - rst_n=0 during read issue cycle 2:
//   - Next cycle IDLE, rsp_valid=0, mem_re=0.
//   - Afterwards, a read of laddr=1 still returns the written line.
// - Back-to-back write then read with rsp_ready tied 1, random req_valid gaps:
//   - Assert !(mem_re&&mem_we) every cycle.
//   - Scoreboard matches every line.
// - STATS_EN: 2 writes + 3 reads -> stat_writes=2, stat_reads=3; reset clears both to 0.

Source files
------------

// File: rtl/sram_line_master_if.sv
// Client request/response and sram bus bundle for sram_line_master.
// Modports: master = controller side, slave = client + sram side.
interface sram_line_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int LINE_WORDS = 4
);
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int LADDR_W = ADDR_WIDTH - OFF_W;
    localparam int LINE_W  = LINE_WORDS * DATA_WIDTH;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [LADDR_W-1:0]    req_laddr;
    logic [LINE_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [LINE_W-1:0]     rsp_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_re;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;

    modport master (
        input  req_valid, req_we, req_laddr, req_wdata,
        input  rsp_ready, mem_data_out,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_addr, mem_re, mem_we, mem_data_in
    );

    modport slave (
        output req_valid, req_we, req_laddr, req_wdata,
        output rsp_ready, mem_data_out,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_addr, mem_re, mem_we, mem_data_in
    );
endinterface

// File: rtl/sram_line_master.sv
// Line-to-word controller for a single-port sram (1-cycle read latency).
// Ports: clk, rst_n (sync, active-low), bus (sram_line_master_if.master);
// with SRAM_LINE_MASTER_STATS_EN: stat_reads, stat_writes (saturating).
module sram_line_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic clk,
    input  logic rst_n,
    sram_line_master_if.master bus
`ifdef SRAM_LINE_MASTER_STATS_EN
    ,
    output logic [15:0] stat_reads,
    output logic [15:0] stat_writes
`endif
);
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int LADDR_W = ADDR_WIDTH - OFF_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [OFF_W-1:0] LAST = OFF_W'(LINE_WORDS - 1);

    logic [1:0]            r_state;
    logic [LADDR_W-1:0]    r_laddr;
    logic [OFF_W-1:0]      r_cnt;
    logic                  r_rd_tail;
    logic                  r_cap_vld;
    logic [OFF_W-1:0]      r_cap_slot;
    logic [ADDR_WIDTH-1:0] r_addr_hold;
    logic [DATA_WIDTH-1:0] r_din_hold;
    logic [DATA_WIDTH-1:0] r_wwords [LINE_WORDS];
    logic [DATA_WIDTH-1:0] r_rwords [LINE_WORDS];

    logic                  w_accept;
    logic                  w_rsp_hs;
    logic                  w_wr_act;
    logic                  w_rd_act;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_din;

    assign bus.req_ready = (r_state == S_IDLE) && rst_n;
    assign bus.rsp_valid = (r_state == S_RESP);

    assign w_accept = bus.req_valid && bus.req_ready;
    assign w_rsp_hs = bus.rsp_valid && bus.rsp_ready;

    // READ spends one extra cycle (tail) only to capture the last word.
    assign w_wr_act = (r_state == S_WRITE);
    assign w_rd_act = (r_state == S_READ) && !r_rd_tail;

    assign w_addr = {r_laddr, r_cnt};
    assign w_din  = r_wwords[r_cnt];

    // Outside active cycles the bus keeps its last driven value.
    assign bus.mem_we      = w_wr_act;
    assign bus.mem_re      = w_rd_act;
    assign bus.mem_addr    = (w_wr_act || w_rd_act) ? w_addr : r_addr_hold;
    assign bus.mem_data_in = w_wr_act ? w_din : r_din_hold;

    always_comb begin
        bus.rsp_rdata = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            bus.rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH] = r_rwords[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_laddr     <= '0;
            r_cnt       <= '0;
            r_rd_tail   <= 1'b0;
            r_cap_vld   <= 1'b0;
            r_cap_slot  <= '0;
            r_addr_hold <= '0;
            r_din_hold  <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                r_wwords[i] <= '0;
                r_rwords[i] <= '0;
            end
        end else begin
            // Word issued this cycle returns next cycle; capture it then.
            r_cap_vld  <= w_rd_act;
            r_cap_slot <= r_cnt;
            if (r_cap_vld) begin
                r_rwords[r_cap_slot] <= bus.mem_data_out;
            end
            if (w_wr_act || w_rd_act) begin
                r_addr_hold <= w_addr;
            end
            if (w_wr_act) begin
                r_din_hold <= w_din;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_laddr   <= bus.req_laddr;
                        r_cnt     <= '0;
                        r_rd_tail <= 1'b0;
                        for (int i = 0; i < LINE_WORDS; i++) begin
                            r_wwords[i] <=
                                bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        r_state <= bus.req_we ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= S_RESP;
                    end
                end
                S_READ: begin
                    if (r_rd_tail) begin
                        r_rd_tail <= 1'b0;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_rd_tail <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SRAM_LINE_MASTER_STATS_EN
    logic r_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            stat_reads  <= '0;
            stat_writes <= '0;
        end else begin
            if (w_accept) begin
                r_we <= bus.req_we;
            end
            if (w_rsp_hs) begin
                if (r_we) begin
                    if (stat_writes != 16'hFFFF) begin
                        stat_writes <= stat_writes + 16'd1;
                    end
                end else begin
                    if (stat_reads != 16'hFFFF) begin
                        stat_reads <= stat_reads + 16'd1;
                    end
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_sram_line_master.sv
// Directed + scoreboard bench for sram_line_master (DW=32, AW=4, 4 words).
// Includes a behavioural single-port sram with 1-cycle read latency.
module tb_sram_line_master;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    bit   mon_en;

    localparam logic [127:0] LINE1 =
        128'h00000044_00000033_00000022_00000011;

    sram_line_master_if #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(4),
        .LINE_WORDS(4)
    ) bus ();

`ifdef SRAM_LINE_MASTER_STATS_EN
    logic [15:0] stat_reads;
    logic [15:0] stat_writes;
`endif

    sram_line_master #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(4),
        .LINE_WORDS(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SRAM_LINE_MASTER_STATS_EN
        ,
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes)
`endif
    );

    logic [31:0] mem [16];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_data_in;
        end
        if (bus.mem_re) begin
            bus.mem_data_out <= mem[bus.mem_addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string        tag,
        input logic [127:0] got,
        input logic [127:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("re_we_excl",
                  128'(bus.mem_re & bus.mem_we), 128'(0));
        end
    end

    // Called at a negedge; returns at the negedge where rsp_valid is seen.
    task automatic line_op(
        input  bit           we,
        input  logic [1:0]   la,
        input  logic [127:0] wd,
        input  bit           pins,
        output logic [127:0] rd
    );
        int         n;
        int         c;
        logic [3:0] base;
        base = {la, 2'b00};
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_laddr = la;
        bus.req_wdata = wd;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 128'(n < 20), 128'(1));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        c = 0;
        while (!bus.rsp_valid && c < 12) begin
            if (pins) begin
                check("mem_we", 128'(bus.mem_we),
                      128'(we && c < 4));
                check("mem_re", 128'(bus.mem_re),
                      128'(!we && c < 4));
                if (c < 4) begin
                    check("mem_addr", 128'(bus.mem_addr),
                          128'(base + 4'(c)));
                end
                if (we && c < 4) begin
                    check("mem_din", 128'(bus.mem_data_in),
                          128'(wd[c*32 +: 32]));
                end
            end
            @(negedge clk);
            c++;
        end
        check("rsp_lat", 128'(c), 128'(we ? 4 : 5));
        rd = bus.rsp_rdata;
    endtask

    logic [127:0] sb [4];
    logic [127:0] rd;
    logic [127:0] wd;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_laddr = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 128'(bus.req_ready), 128'(0));
        check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        check("rst_rsp_rdata", bus.rsp_rdata, 128'(0));
        check("rst_mem_re", 128'(bus.mem_re), 128'(0));
        check("rst_mem_we", 128'(bus.mem_we), 128'(0));
        check("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
        check("rst_mem_din", 128'(bus.mem_data_in), 128'(0));
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 128'(bus.req_ready), 128'(1));

        // Write line 1.
        bus.rsp_ready = 1'b1;
        line_op(1'b1, 2'd1, LINE1, 1'b1, rd);
        sb[1] = LINE1;
        check("wr_rdata_keep", rd, 128'(0));
        check("wr_hold_addr", 128'(bus.mem_addr), 128'(7));
        @(negedge clk);
        check("wr_done_valid", 128'(bus.rsp_valid), 128'(0));
        check("wr_done_ready", 128'(bus.req_ready), 128'(1));

        // Read line 1 with response backpressure.
        bus.rsp_ready = 1'b0;
        line_op(1'b0, 2'd1, 128'(0), 1'b1, rd);
        check("rd_line1", rd, LINE1);
        repeat (3) begin
            check("bp_valid", 128'(bus.rsp_valid), 128'(1));
            check("bp_rdata", bus.rsp_rdata, LINE1);
            check("bp_req_ready", 128'(bus.req_ready), 128'(0));
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_valid", 128'(bus.rsp_valid), 128'(0));
        check("bp_rel_ready", 128'(bus.req_ready), 128'(1));

        // Reset during read issue cycle 2.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_laddr = 2'd1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_re", 128'(bus.mem_re), 128'(1));
        check("mid_addr", 128'(bus.mem_addr), 128'(6));
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 128'(bus.rsp_valid), 128'(0));
        check("mid_rst_re", 128'(bus.mem_re), 128'(0));
        check("mid_rst_rdata", bus.rsp_rdata, 128'(0));
        check("mid_rst_ready", 128'(bus.req_ready), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_idle_ready", 128'(bus.req_ready), 128'(1));
        line_op(1'b0, 2'd1, 128'(0), 1'b0, rd);
        check("mid_reread", rd, LINE1);

        // Fill other lines, then random back-to-back traffic.
        for (int l = 0; l < 4; l++) begin
            if (l != 1) begin
                wd = {$urandom, $urandom, $urandom, $urandom};
                line_op(1'b1, 2'(l), wd, 1'b0, rd);
                sb[l] = wd;
            end
        end
        for (int i = 0; i < 12; i++) begin
            logic [1:0] la;
            bit         we;
            la = 2'($urandom_range(0, 3));
            we = ($urandom_range(0, 2) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (we) begin
                wd = {$urandom, $urandom, $urandom, $urandom};
                line_op(1'b1, la, wd, 1'b0, rd);
                sb[la] = wd;
            end else begin
                line_op(1'b0, la, 128'(0), 1'b0, rd);
                check("sb_read", rd, sb[la]);
            end
        end
        @(negedge clk);

`ifdef SRAM_LINE_MASTER_STATS_EN
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("st_rst_r", 128'(stat_reads), 128'(0));
        check("st_rst_w", 128'(stat_writes), 128'(0));
        line_op(1'b1, 2'd0, sb[0], 1'b0, rd);
        line_op(1'b1, 2'd2, sb[2], 1'b0, rd);
        for (int i = 0; i < 3; i++) begin
            line_op(1'b0, 2'(i), 128'(0), 1'b0, rd);
            check("st_rd", rd, sb[i]);
        end
        @(negedge clk);
        check("st_reads", 128'(stat_reads), 128'(3));
        check("st_writes", 128'(stat_writes), 128'(2));
        rst_n = 1'b0;
        @(negedge clk);
        check("st_clr_r", 128'(stat_reads), 128'(0));
        check("st_clr_w", 128'(stat_writes), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
`endif

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
